pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the RV32I 5-stage pipeline registers. Computes stall, flush and forwarding controls for IF/ID, ID/EX, EX/MEM and MEM/WB.
//  Stalls on imem and dmem wait states and on load-use hazards. Flushes on taken branches/jumps.
//  Runs the interrupt-entry sequence: stop fetch, drain in-flight work, capture EPC, one-cycle redirect.
// PARAMETERS
//  DRAIN_CYCLES  4   non-stalled cycles spent in DRAIN before REDIRECT (D->E->M->W->retire)
//  CNT_W         3   width of drain counter; must hold DRAIN_CYCLES
// PORTS
//  CLK         in   1   clock; all state updates on rising edge
//  RST         in   1   reset, synchronous, active-high
//  Rs1D,Rs2D   in   5   decode-stage source registers
//  Rs1E,Rs2E   in   5   execute-stage source registers
//  RdE         in   5   execute-stage destination
//  LoadE       in   1   instruction in E is a load
//  RdM,RdW     in   5   mem/writeback destinations
//  RegWriteM   in   1   M writes register file
//  RegWriteW   in   1   W writes register file
//  PCSrcE      in   1   taken branch/jump resolved in E
//  PCTargetE   in   32  target of that branch/jump
//  PCF         in   32  current fetch PC
//  IMemReady   in   1   instruction memory data valid this cycle
//  DMemReq     in   1   M-stage load/store active
//  DMemReady   in   1   data memory completes this cycle
//  IrqReq      in   1   level interrupt request
//  IrqEnable   in   1   global interrupt enable
//  StallF,StallD,StallE,StallM  out 1  hold PC / IF_ID / ID_EX / EX_MEM (StallD drives IF_ID EN as ~StallD)
//  FlushD,FlushE,FlushW         out 1  clear IF_ID / ID_EX / MEM_WB next edge
//  ForwardAE,ForwardBE          out 2  00 regfile, 01 from W, 10 from M
//  RedirectIrq out 1   PC mux selects trap vector this cycle
//  IrqAck      out 1   one-cycle pulse, interrupt taken
//  Epc         out 32  return PC of interrupted stream; valid from IrqAck onward
// BEHAVIOUR
//  Hazard terms, combinational:
//   memStall = DMemReq & ~DMemReady
//   lwStall  = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D)
//  Forwarding: ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW & RdW!=0 & RdW==Rs1E; else 00. ForwardBE is identical on Rs2E.
//  Priority, highest first: RST > memStall > PCSrcE > lwStall > ~IMemReady.
//   memStall: StallF=StallD=StallE=StallM=1, FlushW=1; all other flushes 0.
//   PCSrcE: FlushD=FlushE=1.
//   lwStall: StallF=StallD=1, FlushE=1.
//   ~IMemReady (alone): StallF=1, FlushD=1.
//  FSM states: RUN, DRAIN, REDIRECT. Reset -> RUN, cnt=0, Epc=0.
//   RUN -> DRAIN when IrqReq & IrqEnable & ~memStall & ~PCSrcE & ~lwStall & IMemReady. Epc<=PCF on that edge.
//   DRAIN: StallF=1 always. FlushD=~StallD.
//    Hazard rules above still apply. PCSrcE in DRAIN: FlushD=FlushE=1 and Epc<=PCTargetE; the PC is not updated.
//    cnt increments only on cycles with ~memStall & ~lwStall.
//    When cnt==DRAIN_CYCLES-1 and advancing -> REDIRECT, cnt<=0.
//   REDIRECT: exactly 1 cycle. RedirectIrq=1, IrqAck=1, StallF=0, FlushD=1. Next state RUN.
//  Once in DRAIN, entry is committed: IrqReq/IrqEnable deassertion does not abort.
//  RST in any state (mid-DRAIN included): RUN, cnt=0, Epc=0, no IrqAck.
//   While RST=1: FlushD=FlushE=FlushW=1; all stalls, RedirectIrq and IrqAck are 0.
//  Outputs are combinational from state plus inputs; the only registers are state, cnt and Epc. Zero-cycle latency from hazard inputs.
//  Register x0 never forwards and never causes lwStall.
// STRUCTURE
//  Shared package: FSM state encoding (RUN/DRAIN/REDIRECT) and FWD_RF/FWD_W/FWD_M codes, reused by the datapath forwarding muxes.
//  One sub-module: forward_unit (pure combinational, instantiated twice, once per operand). The FSM and stall logic stay in this module.
// TESTING
//  1. RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; Rs1E=0 with RdM=0 -> 00.
//  2. LoadE=1,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle; add PCSrcE=1 same cycle -> FlushD=FlushE=1, StallD=0.
//  3. DMemReq=1,DMemReady=0 for 3 cycles with PCSrcE=1 -> StallF..StallM=1, FlushW=1, FlushD=0 each cycle; release -> flush applied.
//  4. IrqReq=1,IrqEnable=1,PCF=0x100, no hazards -> 4 DRAIN cycles with StallF=1, then IrqAck/RedirectIrq pulse, Epc=0x100, back to RUN.
//  5. In DRAIN cycle 1: PCSrcE=1,PCTargetE=0x200 -> Epc=0x200; 2 dmem-stall cycles mid-drain -> IrqAck delayed by exactly 2 cycles.
//  6. RST asserted in DRAIN cycle 2 -> next cycle state RUN, Epc=0, no IrqAck; IrqReq dropped mid-DRAIN -> IrqAck still issued.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the datapath forwarding muxes.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned FWD_SW = 2;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef enum logic [FWD_SW-1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand bypass select for one execute-stage source register; M wins over W, x0 never forwards.
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output fwd_e             fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage RV32I pipeline plus the interrupt
// entry sequence (stop fetch, drain in-flight work, capture EPC, redirect).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic             LoadE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [XLEN-1:0]  PCF,
  input  logic             IMemReady,
  input  logic             DMemReq,
  input  logic             DMemReady,
  input  logic             IrqReq,
  input  logic             IrqEnable,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [FWD_SW-1:0] ForwardAE,
  output logic [FWD_SW-1:0] ForwardBE,
  output logic             RedirectIrq,
  output logic             IrqAck,
  output logic [XLEN-1:0]  Epc
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  logic mem_stall_c;
  logic lw_stall_c;
  logic advance_c;
  logic irq_take_c;
  fwd_e fwd_a_c;
  fwd_e fwd_b_c;

  forward_unit u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a_c)
  );

  forward_unit u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .reg_write_m (RegWriteM),
    .rd_w        (RdW),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b_c)
  );

  assign ForwardAE = fwd_a_c;
  assign ForwardBE = fwd_b_c;
  assign Epc       = epc_q;

  // Hazard terms; x0 as a load destination never stalls.
  assign mem_stall_c = DMemReq & ~DMemReady;
  assign lw_stall_c  = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign advance_c   = ~mem_stall_c & ~lw_stall_c;
  assign irq_take_c  = IrqReq & IrqEnable & ~mem_stall_c & ~PCSrcE & ~lw_stall_c & IMemReady;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushW      = 1'b0;
    RedirectIrq = 1'b0;
    IrqAck      = 1'b0;

    if (RST) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      if (mem_stall_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall_c) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (!IMemReady) begin
        StallF = 1'b1;
        FlushD = 1'b1;
      end

      unique case (state_q)
        ST_RUN: begin
          if (irq_take_c) begin
            state_d = ST_DRAIN;
            epc_d   = PCF;
          end
        end
        ST_DRAIN: begin
          // Fetch is frozen; the decode slot is bubbled whenever it would advance.
          StallF = 1'b1;
          FlushD = ~StallD;
          if (PCSrcE && !mem_stall_c) begin
            epc_d = PCTargetE;
          end
          if (advance_c) begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
              state_d = ST_REDIRECT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_REDIRECT: begin
          StallF      = 1'b0;
          FlushD      = 1'b1;
          RedirectIrq = 1'b1;
          IrqAck      = 1'b1;
          state_d     = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor compares.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        LoadE, RegWriteM, RegWriteW, PCSrcE;
  logic [31:0] PCTargetE, PCF;
  logic        IMemReady, DMemReq, DMemReady, IrqReq, IrqEnable;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RedirectIrq, IrqAck;
  logic [31:0] Epc;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .PCF(PCF),
    .IMemReady(IMemReady), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .IrqReq(IrqReq), .IrqEnable(IrqEnable),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RedirectIrq(RedirectIrq), .IrqAck(IrqAck), .Epc(Epc)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  stall;   // F,D,E,M
    logic [2:0]  flush;   // D,E,W
    logic [3:0]  fwd;     // A,B
    logic [1:0]  irq;     // RedirectIrq, IrqAck
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference model: interrupt progress described as phase + completed drain steps.
  localparam int DRAIN_STEPS = 4;
  int          m_phase = 0;   // 0 running, 1 draining, 2 redirecting
  int          m_steps = 0;
  logic [31:0] m_epc   = 32'h0;
  int          irq_acks = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic issue();
    exp_t e;
    bit mem, lw, sf, sd, se, sm, fd, fe, fw, rd, ak;
    mem = DMemReq && !DMemReady;
    lw  = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    {sf, sd, se, sm, fd, fe, fw, rd, ak} = '0;
    if (RST) begin
      fd = 1; fe = 1; fw = 1;
    end else begin
      if (mem)             begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
      else if (PCSrcE)     begin fd = 1; fe = 1; end
      else if (lw)         begin sf = 1; sd = 1; fe = 1; end
      else if (!IMemReady) begin sf = 1; fd = 1; end
      if (m_phase == 1) begin sf = 1; fd = !sd; end
      if (m_phase == 2) begin sf = 0; fd = 1; rd = 1; ak = 1; end
    end
    e.stall = {sf, sd, se, sm};
    e.flush = {fd, fe, fw};
    e.fwd   = {ref_fwd(Rs1E), ref_fwd(Rs2E)};
    e.irq   = {rd, ak};
    e.epc   = m_epc;
    exp_q.push_back(e);
    // advance the model to the state after the coming clock edge
    if (RST) begin
      m_phase = 0; m_steps = 0; m_epc = 32'h0;
    end else if (m_phase == 0) begin
      if (IrqReq && IrqEnable && !mem && !PCSrcE && !lw && IMemReady) begin
        m_phase = 1; m_steps = 0; m_epc = PCF;
      end
    end else if (m_phase == 1) begin
      if (PCSrcE && !mem) m_epc = PCTargetE;
      if (!mem && !lw) begin
        m_steps++;
        if (m_steps == DRAIN_STEPS) begin m_phase = 2; m_steps = 0; end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall_FDEM", 32'({StallF, StallD, StallE, StallM}), 32'(e.stall));
        check("flush_DEW",  32'({FlushD, FlushE, FlushW}), 32'(e.flush));
        check("fwd_AB",     32'({ForwardAE, ForwardBE}), 32'(e.fwd));
        check("irq_redir_ack", 32'({RedirectIrq, IrqAck}), 32'(e.irq));
        check("epc", Epc, e.epc);
        if (IrqAck === 1'b1) irq_acks++;
      end
    end
  end

  task automatic quiet();
    RST = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; PCTargetE = 0; PCF = 32'h40;
    IMemReady = 1; DMemReq = 0; DMemReady = 1; IrqReq = 0; IrqEnable = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin tick(); quiet(); issue(); end
  endtask

  initial begin
    int acks_before;
    quiet();
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1; issue();

    // Forwarding priority and x0
    tick(); quiet(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; issue();
    tick(); quiet(); RdW = 6; RegWriteW = 1; Rs2E = 6; RdM = 0; RegWriteM = 1; issue();
    // Load-use, then load-use with a taken branch
    tick(); quiet(); LoadE = 1; RdE = 7; Rs2D = 7; issue();
    tick(); quiet(); LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1; issue();
    tick(); quiet(); LoadE = 1; RdE = 0; Rs1D = 0; issue();
    // dmem wait states dominate a pending branch
    for (int i = 0; i < 3; i++) begin
      tick(); quiet(); DMemReq = 1; DMemReady = 0; PCSrcE = 1; issue();
    end
    tick(); quiet(); DMemReq = 1; DMemReady = 1; PCSrcE = 1; issue();
    tick(); quiet(); IMemReady = 0; issue();

    // Clean interrupt entry
    acks_before = irq_acks;
    tick(); quiet(); IrqReq = 1; IrqEnable = 1; PCF = 32'h100; issue();
    idle(7);
    // Branch in first drain cycle plus two dmem stalls mid-drain
    tick(); quiet(); IrqReq = 1; IrqEnable = 1; PCF = 32'h180; issue();
    tick(); quiet(); PCSrcE = 1; PCTargetE = 32'h200; issue();
    for (int i = 0; i < 2; i++) begin tick(); quiet(); DMemReq = 1; DMemReady = 0; issue(); end
    idle(6);
    // Reset mid-drain
    tick(); quiet(); IrqReq = 1; IrqEnable = 1; PCF = 32'h300; issue();
    idle(1);
    tick(); quiet(); RST = 1; issue();
    idle(6);
    // Request dropped mid-drain still completes
    tick(); quiet(); IrqReq = 1; IrqEnable = 1; PCF = 32'h340; issue();
    idle(7);
    tick(); quiet(); issue();
    total++;
    if (irq_acks - acks_before == 3) passed++;
    else $display("FAIL directed_ack_count: got %0d expected 3", irq_acks - acks_before);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      RST       = ($urandom_range(0, 149) == 0);
      Rs1D      = 5'($urandom_range(0, 3));
      Rs2D      = 5'($urandom_range(0, 3));
      Rs1E      = 5'($urandom_range(0, 3));
      Rs2E      = 5'($urandom_range(0, 3));
      RdE       = 5'($urandom_range(0, 3));
      RdM       = 5'($urandom_range(0, 3));
      RdW       = 5'($urandom_range(0, 3));
      LoadE     = ($urandom_range(0, 3) == 0);
      RegWriteM = $urandom_range(0, 1) != 0;
      RegWriteW = $urandom_range(0, 1) != 0;
      PCSrcE    = ($urandom_range(0, 7) == 0);
      PCTargetE = $urandom;
      PCF       = $urandom;
      IMemReady = ($urandom_range(0, 7) != 0);
      DMemReq   = ($urandom_range(0, 2) == 0);
      DMemReady = $urandom_range(0, 1) != 0;
      IrqReq    = ($urandom_range(0, 5) == 0);
      IrqEnable = ($urandom_range(0, 3) != 0);
      issue();
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      total++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    @(posedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
